// File: rtl/pkg_amba3.sv
// Shared AMBA 3 AXI types and helpers for the amba3_axi_ram slice.
package pkg_amba3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_t;

  localparam int AXI_MAX_BEATS = 16;

  // True when a burst descriptor is legal for a bus of 2**strb_log2 bytes.
  function automatic logic axi_burst_valid(input logic [3:0] len, input logic [2:0] size,
                                           input logic [1:0] burst, input logic [2:0] strb_log2);
    logic ok;
    ok = (size <= strb_log2) && (burst != BURST_RSVD);
    if (burst == BURST_WRAP)
      ok = ok && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
    return ok;
  endfunction

endpackage

// File: rtl/amba3_axi_burst_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module amba3_axi_burst_addr
  import pkg_amba3::*;
#(
  parameter int ADDR_SIZE = 32
) (
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [3:0]           len,
  input  logic [2:0]           size,
  input  logic [1:0]           burst,
  output logic [ADDR_SIZE-1:0] next_addr
);

  logic [ADDR_SIZE-1:0] step;
  logic [ADDR_SIZE-1:0] aligned;
  logic [ADDR_SIZE-1:0] incr;
  logic [ADDR_SIZE-1:0] wrap_mask;

  // Align to the transfer size, step one transfer, and fold into the wrap window when needed.
  always_comb begin
    step      = ADDR_SIZE'(1) << size;
    aligned   = addr & ~(step - ADDR_SIZE'(1));
    incr      = aligned + step;
    wrap_mask = ((ADDR_SIZE'(len) + ADDR_SIZE'(1)) << size) - ADDR_SIZE'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/amba3_axi_ram.sv
// AXI3 slave RAM: one write and one read burst at a time on independent channels.
// Optional feature macro AMBA3_AXI_RAM_DECERR_EN: out-of-range word indices give DECERR
// instead of aliasing modulo the memory depth.
module amba3_axi_ram
  import pkg_amba3::*;
#(
  parameter int TXID_SIZE  = 4,
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_SIZE  = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic [TXID_SIZE-1:0]   awid,
  input  logic [ADDR_SIZE-1:0]   awaddr,
  input  logic [3:0]             awlen,
  input  logic [2:0]             awsize,
  input  logic [1:0]             awburst,
  input  logic [1:0]             awlock,
  input  logic [3:0]             awcache,
  input  logic [2:0]             awprot,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [TXID_SIZE-1:0]   wid,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wstrb,
  input  logic                   wlast,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [TXID_SIZE-1:0]   bid,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [TXID_SIZE-1:0]   arid,
  input  logic [ADDR_SIZE-1:0]   araddr,
  input  logic [3:0]             arlen,
  input  logic [2:0]             arsize,
  input  logic [1:0]             arburst,
  input  logic [1:0]             arlock,
  input  logic [3:0]             arcache,
  input  logic [2:0]             arprot,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [TXID_SIZE-1:0]   rid,
  output logic [DATA_SIZE-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   rlast,
  output logic                   rvalid,
  input  logic                   rready
);

  localparam int STRB_SIZE = DATA_SIZE / 8;
  localparam int STRB_LOG2 = $clog2(STRB_SIZE);
  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int BEAT_W    = $clog2(AXI_MAX_BEATS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [DATA_SIZE-1:0] mem [0:DEPTH-1];
  logic [DATA_SIZE-1:0] mem_q;

  w_state_t             w_state;
  logic                 awready_reg, wready_reg, bvalid_reg;
  resp_type_t           bresp_reg;
  logic [TXID_SIZE-1:0] wtxid_reg;
  logic [ADDR_SIZE-1:0] waddr_reg, waddr_next;
  logic [3:0]           wlen_reg;
  logic [2:0]           wsize_reg;
  logic [1:0]           wburst_reg;
  logic [BEAT_W-1:0]    wbeat_reg;
  logic                 wbad_burst_reg, wslverr_reg, wdecerr_reg;

  r_state_t             r_state;
  logic                 arready_reg, rvalid_reg, rlast_reg, rdata_ok_reg;
  resp_type_t           rresp_reg;
  logic [TXID_SIZE-1:0] rtxid_reg;
  logic [ADDR_SIZE-1:0] raddr_reg, raddr_next;
  logic [3:0]           rlen_reg;
  logic [2:0]           rsize_reg;
  logic [1:0]           rburst_reg;
  logic [BEAT_W-1:0]    rbeat_reg;
  logic                 rbad_burst_reg;

  logic [DEPTH_LOG2-1:0] w_word, r_word;
  logic                  w_oor, r_oor;
  logic                  w_hs, w_beat_last, w_beat_err, mem_we;

  // Protection/cache/lock attributes carry no meaning for a plain RAM.
  logic unused_ok;
  assign unused_ok = &{1'b0, awlock, awcache, awprot, arlock, arcache, arprot};

  assign w_word = waddr_reg[STRB_LOG2 +: DEPTH_LOG2];
  assign r_word = raddr_reg[STRB_LOG2 +: DEPTH_LOG2];

`ifdef AMBA3_AXI_RAM_DECERR_EN
  assign w_oor = |waddr_reg[ADDR_SIZE-1:STRB_LOG2+DEPTH_LOG2];
  assign r_oor = |raddr_reg[ADDR_SIZE-1:STRB_LOG2+DEPTH_LOG2];
`else
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
`endif

  assign w_hs        = wvalid && wready_reg;
  assign w_beat_last = (wbeat_reg == wlen_reg);
  assign w_beat_err  = (wid != wtxid_reg) || (wlast != w_beat_last);
  assign mem_we      = w_hs && !wbad_burst_reg && !w_oor;

  amba3_axi_burst_addr #(.ADDR_SIZE(ADDR_SIZE)) u_waddr (
    .addr(waddr_reg), .len(wlen_reg), .size(wsize_reg), .burst(wburst_reg), .next_addr(waddr_next)
  );

  amba3_axi_burst_addr #(.ADDR_SIZE(ADDR_SIZE)) u_raddr (
    .addr(raddr_reg), .len(rlen_reg), .size(rsize_reg), .burst(rburst_reg), .next_addr(raddr_next)
  );

  // Write channel: accept address, absorb beats while tracking errors, then hold the response.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_state        <= W_IDLE;
      awready_reg    <= 1'b0;
      wready_reg     <= 1'b0;
      bvalid_reg     <= 1'b0;
      bresp_reg      <= RESP_OKAY;
      wtxid_reg      <= '0;
      waddr_reg      <= '0;
      wlen_reg       <= '0;
      wsize_reg      <= '0;
      wburst_reg     <= '0;
      wbeat_reg      <= '0;
      wbad_burst_reg <= 1'b0;
      wslverr_reg    <= 1'b0;
      wdecerr_reg    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready_reg <= 1'b1;
          if (awvalid && awready_reg) begin
            awready_reg    <= 1'b0;
            wready_reg     <= 1'b1;
            wtxid_reg      <= awid;
            waddr_reg      <= awaddr;
            wlen_reg       <= awlen;
            wsize_reg      <= awsize;
            wburst_reg     <= awburst;
            wbeat_reg      <= '0;
            wbad_burst_reg <= !axi_burst_valid(awlen, awsize, awburst, 3'(STRB_LOG2));
            wslverr_reg    <= !axi_burst_valid(awlen, awsize, awburst, 3'(STRB_LOG2));
            wdecerr_reg    <= 1'b0;
            w_state        <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            waddr_reg <= waddr_next;
            wbeat_reg <= wbeat_reg + 1'b1;
            if (w_beat_err) wslverr_reg <= 1'b1;
            if (w_oor)      wdecerr_reg <= 1'b1;
            if (w_beat_last) begin
              wready_reg <= 1'b0;
              bvalid_reg <= 1'b1;
              if (wslverr_reg || w_beat_err) bresp_reg <= RESP_SLVERR;
              else if (wdecerr_reg || w_oor) bresp_reg <= RESP_DECERR;
              else                           bresp_reg <= RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: one fetch cycle per beat, then hold the beat until the master takes it.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state        <= R_IDLE;
      arready_reg    <= 1'b0;
      rvalid_reg     <= 1'b0;
      rlast_reg      <= 1'b0;
      rdata_ok_reg   <= 1'b0;
      rresp_reg      <= RESP_OKAY;
      rtxid_reg      <= '0;
      raddr_reg      <= '0;
      rlen_reg       <= '0;
      rsize_reg      <= '0;
      rburst_reg     <= '0;
      rbeat_reg      <= '0;
      rbad_burst_reg <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_reg <= 1'b1;
          if (arvalid && arready_reg) begin
            arready_reg    <= 1'b0;
            rtxid_reg      <= arid;
            raddr_reg      <= araddr;
            rlen_reg       <= arlen;
            rsize_reg      <= arsize;
            rburst_reg     <= arburst;
            rbeat_reg      <= '0;
            rbad_burst_reg <= !axi_burst_valid(arlen, arsize, arburst, 3'(STRB_LOG2));
            r_state        <= R_FETCH;
          end
        end
        R_FETCH: begin
          rvalid_reg   <= 1'b1;
          rlast_reg    <= (rbeat_reg == rlen_reg);
          rdata_ok_reg <= !rbad_burst_reg && !r_oor;
          if (rbad_burst_reg) rresp_reg <= RESP_SLVERR;
          else if (r_oor)     rresp_reg <= RESP_DECERR;
          else                rresp_reg <= RESP_OKAY;
          r_state <= R_DATA;
        end
        R_DATA: begin
          if (rready) begin
            rvalid_reg   <= 1'b0;
            rlast_reg    <= 1'b0;
            rdata_ok_reg <= 1'b0;
            if (rlast_reg) begin
              arready_reg <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              raddr_reg <= raddr_next;
              rbeat_reg <= rbeat_reg + 1'b1;
              r_state   <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Byte-lane write port plus read-first registered read port; mem_q only moves during a fetch.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_SIZE; i++)
        if (wstrb[i]) mem[w_word][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (r_state == R_FETCH) mem_q <= mem[r_word];
  end

  assign awready = awready_reg;
  assign wready  = wready_reg;
  assign bvalid  = bvalid_reg;
  assign bresp   = bresp_reg;
  assign bid     = wtxid_reg;
  assign arready = arready_reg;
  assign rvalid  = rvalid_reg;
  assign rlast   = rlast_reg;
  assign rresp   = rresp_reg;
  assign rid     = rtxid_reg;
  assign rdata   = rdata_ok_reg ? mem_q : '0;

endmodule

// File: doc/amba3_axi_ram.md
# amba3_axi_ram

Synthesizable AMBA 3 AXI slave memory that sits directly downstream of the `amba3_axi_if` master side and is the RTL target the master VIP drives. It accepts one write burst and one read burst at a time, on independent channels that run concurrently. It supports FIXED, INCR and WRAP bursts up to 16 beats and returns per-beat read data and one write response per burst.

## Interface
- TXID_SIZE, 4, transaction ID width
- ADDR_SIZE, 32, byte address width
- DATA_SIZE, 32, data width in bits (32/64/128); STRB_SIZE = DATA_SIZE/8
- DEPTH_LOG2, 10, log2 of memory depth in DATA_SIZE words
- aclk  in  1  single clock; all logic on rising edge
- areset_n  in  1  reset, asynchronous assert, active-low
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  TXID/ADDR/4/3/2/2/4/3  write address; awlock/awcache/awprot ignored
- awvalid in 1, awready out 1  write address handshake
- wid/wdata/wstrb/wlast/wvalid  in  TXID/DATA/STRB/1/1, wready out 1  write data
- bid out TXID, bresp out 2, bvalid out 1, bready in 1  write response
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  as aw*; arvalid in 1, arready out 1  read address
- rid out TXID, rdata out DATA, rresp out 2, rlast out 1, rvalid out 1, rready in 1  read data

## Operation
- Reset (areset_n=0, async): all ready/valid/last = 0, bid/rid/rdata = 0, bresp/rresp = OKAY, both FSMs IDLE. Memory contents are not reset. A burst in flight is abandoned with no response.
- Write FSM W_IDLE→W_DATA→W_RESP:
  - W_IDLE: awready=1. On handshake, capture id/addr/len/size/burst, clear beat counter, go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes the lanes where wstrb=1 to mem[addr>>log2(STRB_SIZE)], then advances the address. On beat == awlen, go to W_RESP.
  - W_RESP: bvalid=1 with bid=captured awid, held until bready, then go to W_IDLE.
- Write errors: bresp = SLVERR if wid≠awid on any beat, wlast≠(beat==awlen) on any beat, awsize>log2(STRB_SIZE), burst=2'b11, or WRAP with len∉{1,3,7,15}. For the size/burst/WRAP errors, memory writes are suppressed for the whole burst. The beat count always governs burst length.
- Read FSM R_IDLE→R_FETCH→R_DATA:
  - R_IDLE: arready=1. On handshake, capture fields and go to R_FETCH.
  - R_FETCH: synchronous memory read of the current word, go to R_DATA.
  - R_DATA: rvalid=1 with rdata, rid, rlast=(beat==arlen) and rresp held stable until rready. On handshake: if last, go to R_IDLE; otherwise advance the address and go to R_FETCH.
  - Read errors use the same conditions as writes and give rresp=SLVERR, rdata=0. Every beat is still returned.
- Address step (same for both channels):
  - FIXED: address unchanged.
  - INCR: next = (addr aligned to size) + (1<<size).
  - WRAP: as INCR, but wraps within a window of (len+1)<<size bytes aligned to that size.
  - Only the first INCR beat may be unaligned.
- Simultaneous read fetch and write to the same word: the read returns the old data.

## Timing
- AW handshake at edge N: wready=1 from edge N+1.
- Last W handshake at edge M: bvalid=1 from edge M+1.
- AR handshake at edge N: rvalid=1 from edge N+2.
- Read throughput is 1 beat per 2 cycles when rready is held at 1.
- awready and arready go to 1 on the first edge after reset release.

## Configuration
- AMBA3_AXI_RAM_DECERR_EN defined: an address whose word index is ≥ 2^DEPTH_LOG2 gives DECERR for that burst (bresp), or for that beat (rresp with rdata=0). Writes to such addresses are suppressed.
- Not defined: the word index is taken modulo 2^DEPTH_LOG2 (aliasing) and no DECERR is ever produced.

## Structure
- pkg_amba3 supplies burst_type_t and resp_type_t. Add the following to pkg_amba3:
  - function axi_burst_valid(len, size, burst, strb_log2)
  - constant AXI_MAX_BEATS = 16
- Sub-module amba3_axi_burst_addr: combinational next-address from (addr, len, size, burst), instantiated once per channel.

## Test plan
- INCR write awaddr=0x10, len=3, size=2, data 0x11..0x44, wstrb=0xF; then INCR read of the same range → rdata 0x11,0x22,0x33,0x44, rlast on beat 3 only, bresp=rresp=OKAY, rid=bid=awid.
- WRAP read araddr=0x08, len=3, size=2 over words 0x00..0x0C → word order 0x08, 0x0C, 0x00, 0x04.
- Write wstrb=0x3 of 0xAABBCCDD over 0xFFFFFFFF, then read back → 0xFFFFCCDD.
- Write with wid≠awid, or wlast missing on the final beat → bresp=SLVERR. arsize=3 with DATA_SIZE=32 → rresp=SLVERR on every beat.
- With DECERR_EN, read at word index 2^DEPTH_LOG2 → DECERR. Without it, the same read returns the content of word 0.
- Deassert areset_n during R_DATA with rready=0 → rvalid=0 immediately (asynchronously). After release, arready=1 on the next edge and a new read completes normally.
